// File: rtl/midi_pkg.sv
// Shared MIDI transmit-side types: byte width, arbiter state encoding and
// a status-byte helper for the merge and arbitration logic.
package midi_pkg;

    localparam int MIDI_BYTE_W = 8;

    typedef enum logic [2:0] {
        SELECT,
        LOAD,
        STROBE,
        WAIT_START,
        WAIT_DONE
    } arb_state_t;

    // MIDI status bytes carry bit 7 set; data bytes never do.
    function automatic logic is_status(input logic [MIDI_BYTE_W-1:0] b);
        return b[MIDI_BYTE_W-1];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first asserted request at
// or after ptr, wrapping modulo NUM_REQ (non-power-of-2 counts supported).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    logic [IDX_W-1:0] cand [NUM_REQ];

    // cand[gi] is the request index examined at priority rank gi.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                          IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
    end

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                grant   = cand[k];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one uart_tx between NUM_SRC
// byte streams, with owner-stall and UART-unresponsive recovery.
module midi_tx_arbiter import midi_pkg::*; #(
    parameter int NUM_SRC      = 4,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int BUSY_WAIT    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [MIDI_BYTE_W*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]             src_last,
    output logic [NUM_SRC-1:0]             src_ready,
    output logic                           tx_strobe,
    output logic [MIDI_BYTE_W-1:0]         tx_data,
    input  logic                           tx_busy,
    output logic [$clog2(NUM_SRC)-1:0]     grant_id,
    output logic                           locked,
    output logic                           lock_timeout,
    output logic                           tx_fault
);

    localparam int GW     = $clog2(NUM_SRC);
    localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int WAIT_W = $clog2(BUSY_WAIT + 1);

    arb_state_t             state_reg, state_next;
    logic [GW-1:0]          grant_reg, grant_next;
    logic [GW-1:0]          ptr_reg, ptr_next;
    logic                   locked_reg, locked_next;
    logic [IDLE_W-1:0]      idle_cnt_reg, idle_cnt_next;
    logic [WAIT_W-1:0]      wait_cnt_reg, wait_cnt_next;
    logic [MIDI_BYTE_W-1:0] tx_data_reg, tx_data_next;
    logic                   last_reg, last_next;

    logic [MIDI_BYTE_W-1:0] src_byte [NUM_SRC];
    logic [GW-1:0]          pick_id;
    logic                   pick_any;
    logic                   owner_valid;
    logic [MIDI_BYTE_W-1:0] owner_data;
    logic                   owner_last;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign src_byte[gi] = src_data[MIDI_BYTE_W*gi +: MIDI_BYTE_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_SRC),
        .IDX_W   (GW)
    ) u_rr_pick (
        .req     (src_valid),
        .ptr     (ptr_reg),
        .grant   (pick_id),
        .any_req (pick_any)
    );

    assign owner_valid = src_valid[grant_reg];
    assign owner_data  = src_byte[grant_reg];
    assign owner_last  = src_last[grant_reg];

    function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] i);
        return (int'(i) == NUM_SRC - 1) ? '0 : i + GW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= SELECT;
            grant_reg    <= '0;
            ptr_reg      <= '0;
            locked_reg   <= 1'b0;
            idle_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            tx_data_reg  <= '0;
            last_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            ptr_reg      <= ptr_next;
            locked_reg   <= locked_next;
            idle_cnt_reg <= idle_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            tx_data_reg  <= tx_data_next;
            last_reg     <= last_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        ptr_next      = ptr_reg;
        locked_next   = locked_reg;
        idle_cnt_next = idle_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        tx_data_next  = tx_data_reg;
        last_next     = last_reg;
        src_ready     = '0;
        tx_strobe     = 1'b0;
        lock_timeout  = 1'b0;
        tx_fault      = 1'b0;

        case (state_reg)
            SELECT: begin
                if (locked_reg) begin
                    // Only the owner may continue; everyone else waits out the lock.
                    if (owner_valid) begin
                        state_next    = LOAD;
                        idle_cnt_next = '0;
                    end else if (idle_cnt_reg == IDLE_W'(LOCK_TIMEOUT - 1)) begin
                        lock_timeout  = 1'b1;
                        locked_next   = 1'b0;
                        ptr_next      = next_idx(grant_reg);
                        idle_cnt_next = '0;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
                    end
                end else if (pick_any) begin
                    grant_next    = pick_id;
                    locked_next   = 1'b1;
                    idle_cnt_next = '0;
                    state_next    = LOAD;
                end
            end
            LOAD: begin
                src_ready[grant_reg] = 1'b1;
                if (owner_valid) begin
                    tx_data_next = owner_data;
                    last_next    = owner_last;
                    state_next   = STROBE;
                end else begin
                    state_next   = SELECT;
                end
            end
            STROBE: begin
                tx_strobe     = 1'b1;
                wait_cnt_next = '0;
                state_next    = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (wait_cnt_reg == WAIT_W'(BUSY_WAIT - 1)) begin
                    // UART never acknowledged: drop the byte and the message.
                    tx_fault    = 1'b1;
                    locked_next = 1'b0;
                    ptr_next    = next_idx(grant_reg);
                    state_next  = SELECT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_reg) begin
                        locked_next = 1'b0;
                        ptr_next    = next_idx(grant_reg);
                    end
                    state_next = SELECT;
                end
            end
            default: state_next = SELECT;
        endcase
    end

    assign tx_data  = tx_data_reg;
    assign grant_id = grant_reg;
    assign locked   = locked_reg;

endmodule

// File: tb/tb_midi_tx_arbiter.sv
// Scoreboard bench for midi_tx_arbiter: per-source byte queues feed the DUT,
// a uart_tx stub answers strobes, and each strobe is matched against the queue.
module tb_midi_tx_arbiter;

    localparam int NUM_SRC = 4;
    localparam int LT      = 64;
    localparam int BW      = 4;
    localparam int BUSY_DLY = 1;
    localparam int BUSY_LEN = 4;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
        logic       gap;
        logic       after_lt;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic [NUM_SRC-1:0]     src_valid;
    logic [8*NUM_SRC-1:0]   src_data;
    logic [NUM_SRC-1:0]     src_last;
    logic [NUM_SRC-1:0]     src_ready;
    logic                   tx_strobe;
    logic [7:0]             tx_data;
    logic                   tx_busy;
    logic [1:0]             grant_id;
    logic                   locked;
    logic                   lock_timeout;
    logic                   tx_fault;

    logic [8:0] srcq [NUM_SRC][$];
    exp_t       exp_q [$];

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  fall_cyc = 0;
    int  lt_cyc = 0;
    int  strobe_cyc = 0;
    int  lt_cnt = 0;
    int  fault_cnt = 0;
    bit  seen_3c = 0;
    bit  uart_stuck = 0;

    midi_tx_arbiter #(
        .NUM_SRC      (NUM_SRC),
        .LOCK_TIMEOUT (LT),
        .BUSY_WAIT    (BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .tx_strobe    (tx_strobe),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .locked       (locked),
        .lock_timeout (lock_timeout),
        .tx_fault     (tx_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic push_byte(input int s, input logic [7:0] d, input logic last,
                             input logic gap, input logic after_lt);
        exp_t e;
        srcq[s].push_back({last, d});
        e.src = 2'(s);
        e.data = d;
        e.gap = gap;
        e.after_lt = after_lt;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done = 0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && src_valid == '0 && !tx_busy && !locked &&
                srcq[0].size() == 0 && srcq[1].size() == 0 &&
                srcq[2].size() == 0 && srcq[3].size() == 0) begin
                done = 1;
                break;
            end
        end
        check_eq(tag, 32'(done), 32'd1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    // Source drivers: a byte leaves its queue once valid&ready was seen.
    initial begin
        logic [NUM_SRC-1:0] xfer;
        logic [8:0] h;
        src_valid = '0;
        src_data  = '0;
        src_last  = '0;
        forever begin
            @(negedge clk);
            xfer = src_valid & src_ready & {NUM_SRC{rst}};
            @(posedge clk); #1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (xfer[i]) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    h = srcq[i][0];
                    src_valid[i] = 1'b1;
                    src_last[i]  = h[8];
                    src_data[8*i +: 8] = h[7:0];
                end else begin
                    src_valid[i] = 1'b0;
                    src_last[i]  = 1'b0;
                    src_data[8*i +: 8] = 8'h00;
                end
            end
        end
    end

    // uart_tx stub: busy rises BUSY_DLY cycles after a strobe, lasts BUSY_LEN.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_strobe && !uart_stuck) begin
                repeat (BUSY_DLY) begin @(posedge clk); #1; end
                tx_busy = 1'b1;
                repeat (BUSY_LEN) begin @(posedge clk); #1; end
                tx_busy = 1'b0;
            end
        end
    end

    // Output monitor: one scoreboard entry per strobe, plus pulse timing.
    initial begin
        bit   prev_busy = 0;
        bit   prev_strobe = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_strobe) begin
                check_eq("strobe_width", 32'(prev_strobe), 32'd0);
                check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("tx_data", 32'(tx_data), 32'(e.data));
                    check_eq("grant_id", 32'(grant_id), 32'(e.src));
                    check_eq("locked_at_strobe", 32'(locked), 32'd1);
                    if (e.gap) check_eq("busy_fall_to_strobe", 32'(cyc - fall_cyc), 32'd3);
                    if (e.after_lt) check_eq("timeout_to_strobe", 32'(cyc - lt_cyc), 32'd3);
                end
                if (tx_data == 8'h3C) seen_3c = 1;
                strobe_cyc = cyc;
            end
            if (lock_timeout) begin
                lt_cnt++;
                check_eq("timeout_delay", 32'(cyc - fall_cyc), 32'(LT));
                lt_cyc = cyc;
            end
            if (tx_fault) begin
                fault_cnt++;
                check_eq("fault_delay", 32'(cyc - strobe_cyc), 32'(BW));
            end
            if (!tx_busy && prev_busy) fall_cyc = cyc;
            prev_busy = tx_busy;
            prev_strobe = tx_strobe;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_ready", 32'(src_ready), 32'd0);
        check_eq("rst_strobe", 32'(tx_strobe), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_pulses", 32'({lock_timeout, tx_fault}), 32'd0);
        rst = 1'b1;

        // Single-byte F8 messages from all sources: grants rotate 0,1,2,3,0,...
        @(negedge clk);
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NUM_SRC; s++)
                push_byte(s, 8'hF8, 1'b1, (r != 0 || s != 0), 1'b0);
        wait_idle("idle_after_f8", 3000);

        // Note On from src0 while src1's Program Change waits behind the lock.
        @(negedge clk);
        push_byte(0, 8'h90, 1'b0, 1'b0, 1'b0);
        push_byte(0, 8'h3C, 1'b0, 1'b1, 1'b0);
        push_byte(0, 8'h64, 1'b1, 1'b1, 1'b0);
        push_byte(1, 8'hC0, 1'b0, 1'b1, 1'b0);
        push_byte(1, 8'h05, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("lat_valid_k", 32'(src_valid), 32'h3);
        check_eq("lat_ready_k", 32'(src_ready), 32'd0);
        @(negedge clk);
        check_eq("lat_ready_k1", 32'(src_ready), 32'h1);
        @(negedge clk);
        check_eq("lat_strobe_k2", 32'(tx_strobe), 32'd1);
        wait_idle("idle_after_msgs", 3000);

        // Reset while byte 3C is in WAIT_DONE; 64 is re-sent after release.
        seen_3c = 0;
        @(negedge clk);
        push_byte(0, 8'h90, 1'b0, 1'b0, 1'b0);
        push_byte(0, 8'h3C, 1'b0, 1'b1, 1'b0);
        push_byte(0, 8'h64, 1'b1, 1'b0, 1'b0);
        found = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #2;
            if (seen_3c) begin found = 1; break; end
        end
        check_eq("saw_3c", 32'(found), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        check_eq("midrst_ready", 32'(src_ready), 32'd0);
        check_eq("midrst_strobe", 32'(tx_strobe), 32'd0);
        check_eq("midrst_tx_data", 32'(tx_data), 32'd0);
        check_eq("midrst_grant", 32'(grant_id), 32'd0);
        check_eq("midrst_locked", 32'(locked), 32'd0);
        check_eq("midrst_pulses", 32'({lock_timeout, tx_fault}), 32'd0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        wait_idle("idle_after_reset", 3000);

        // src2 stalls mid-message; src3 is served only after the lock is revoked.
        @(negedge clk);
        push_byte(2, 8'h80, 1'b0, 1'b0, 1'b0);
        push_byte(2, 8'h40, 1'b0, 1'b1, 1'b0);
        push_byte(3, 8'hB0, 1'b1, 1'b0, 1'b1);
        wait_idle("idle_after_timeout", 5000);
        check_eq("timeout_count", 32'(lt_cnt), 32'd1);

        // UART never raises busy for src1's byte; arbiter recovers and moves on.
        uart_stuck = 1;
        @(negedge clk);
        push_byte(1, 8'hA0, 1'b1, 1'b0, 1'b0);
        found = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #2;
            if (fault_cnt != 0) begin found = 1; break; end
        end
        check_eq("saw_fault", 32'(found), 32'd1);
        check_eq("fault_unlocked", 32'(locked), 32'd0);
        uart_stuck = 0;
        @(negedge clk);
        push_byte(2, 8'hC5, 1'b1, 1'b0, 1'b0);
        push_byte(0, 8'h42, 1'b1, 1'b1, 1'b0);
        wait_idle("idle_after_fault", 3000);

        check_eq("fault_count", 32'(fault_cnt), 32'd1);
        check_eq("timeout_count_end", 32'(lt_cnt), 32'd1);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
